transition_recorder: RTL and testbench

Parametrised record-and-playback engine for a single button/level input. In RECORD mode it stores the clock-cycle interval between successive transitions of `din` into a DEPTH-entry memory. In PLAY mode it regenerates the same waveform on `dout`, once or looped. It sits behind the board-level debouncer/synchroniser and drives an LED or any downstream consumer of a level sequence.

---
 rtl/transition_recorder.sv | 154 +++++++++++++++
 tb/tb_transition_recorder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/transition_recorder.sv
// Record-and-playback engine: captures cycle intervals between din transitions
// and regenerates the same level sequence on dout, once or looped.
module transition_recorder #(
  parameter  int DEPTH  = 32,
  parameter  int CNT_W  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              record,
  input  logic              play,
  input  logic              loop_en,
  input  logic              din,
  output logic              dout,
  output logic              recording,
  output logic              playing,
  output logic              full,
  output logic              done,
  output logic [ADDR_W:0]   length
);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);

  typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;

  state_t            state;
  logic              rec_q, play_q, prev;
  logic              rec_rise, play_rise, play_start, we, tick, last;
  logic [CNT_W-1:0]  mem [DEPTH];
  logic [CNT_W-1:0]  cnt, timer, rd_data;
  logic [ADDR_W:0]   rd_ptr, rd_addr;

  // Index following p within the stored sequence, wrapping to 0 after the last entry.
  function automatic logic [ADDR_W:0] succ(input logic [ADDR_W:0] p, input logic [ADDR_W:0] len);
    succ = (p + ONE == len) ? '0 : p + ONE;
  endfunction

  assign rec_rise   = record & ~rec_q;
  assign play_rise  = play & ~play_q;
  assign play_start = (state == IDLE) && !rec_rise && play_rise && (length != '0);
  assign we         = (state == RECORD) && record && (din != prev);
  assign tick       = (timer == CNT_W'(1));
  assign last       = (rd_ptr == length - ONE);

  // rd_data always holds the interval that will be loaded at the next timer expiry,
  // so a stored interval of 1 still gets its own toggle.
  always_comb begin
    rd_addr = '0;
    if (reset)
      rd_addr = '0;
    else if (play_start)
      rd_addr = succ('0, length);
    else if (state == PLAY && play) begin
      if (tick && last)
        rd_addr = loop_en ? succ('0, length) : '0;
      else if (tick)
        rd_addr = succ(rd_ptr + ONE, length);
      else
        rd_addr = succ(rd_ptr, length);
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[length[ADDR_W-1:0]] <= cnt;
    rd_data <= (we && rd_addr == length) ? cnt : mem[rd_addr[ADDR_W-1:0]];
  end

  // Edge detectors follow their inputs through reset so a level held across
  // reset release is not mistaken for a fresh request.
  always_ff @(posedge clk) begin
    rec_q  <= record;
    play_q <= play;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dout      <= 1'b0;
      recording <= 1'b0;
      playing   <= 1'b0;
      full      <= 1'b0;
      done      <= 1'b0;
      length    <= '0;
      cnt       <= '0;
      prev      <= 1'b0;
      rd_ptr    <= '0;
      timer     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rec_rise) begin
            state     <= RECORD;
            recording <= 1'b1;
            length    <= '0;
            full      <= 1'b0;
            cnt       <= CNT_W'(1);
            prev      <= 1'b0;
            dout      <= 1'b0;
          end else if (play_start) begin
            state   <= PLAY;
            playing <= 1'b1;
            rd_ptr  <= '0;
            dout    <= 1'b0;
            timer   <= rd_data;
          end
        end
        RECORD: begin
          if (!record) begin
            state     <= IDLE;
            recording <= 1'b0;
          end else if (din != prev) begin
            length <= length + ONE;
            cnt    <= CNT_W'(1);
            prev   <= din;
            if (length == LAST_IDX) begin
              full      <= 1'b1;
              state     <= IDLE;
              recording <= 1'b0;
            end
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PLAY: begin
          if (!play) begin
            dout    <= 1'b0;
            state   <= IDLE;
            playing <= 1'b0;
          end else if (tick) begin
            timer <= rd_data;
            if (last) begin
              done <= 1'b1;
              if (loop_en) begin
                dout   <= 1'b0;
                rd_ptr <= '0;
              end else begin
                dout    <= ~dout;
                state   <= IDLE;
                playing <= 1'b0;
              end
            end else begin
              dout   <= ~dout;
              rd_ptr <= rd_ptr + ONE;
            end
          end else begin
            timer <= timer - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_transition_recorder.sv
// Scoreboard bench: expected dout/done events come from a timestamp model of the
// recorded waveform; a negedge monitor pops them whenever dout changes or done pulses.
module tb_transition_recorder;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset, record, play, loop_en, din;
  logic dout, recording, playing, full, done;
  logic [ADDR_W:0] length;

  transition_recorder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .record(record), .play(play), .loop_en(loop_en),
    .din(din), .dout(dout), .recording(recording), .playing(playing),
    .full(full), .done(done), .length(length)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; bit dout; bit done;} ev_t;
  ev_t exp_q[$];
  ev_t mon_e;
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  mon_on = 1'b0;
  bit  last_dout = 1'b0;
  int  m_mem[$];
  bit  m_full = 1'b0;
  bit  m_dout = 1'b0;
  bit  din_seq[$];
  int  iv_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int c, input bit d, input bit dn);
    ev_t e;
    e.cyc = c; e.dout = d; e.done = dn;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      if (dout !== last_dout || done === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_event", cyc, -1);
        else begin
          mon_e = exp_q.pop_front();
          chk("evt_cycle", cyc, mon_e.cyc);
          chk("evt_dout", int'(dout), int'(mon_e.dout));
          chk("evt_done", int'(done), int'(mon_e.done));
        end
      end
      last_dout = dout;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // din level per edge after RECORD entry, from a list of intervals between transitions.
  function automatic void build_seq(input int tail);
    bit lv;
    lv = 1'b0;
    din_seq.delete();
    foreach (iv_q[k]) begin
      repeat (iv_q[k] - 1) din_seq.push_back(lv);
      lv = !lv;
      din_seq.push_back(lv);
    end
    repeat (tail) din_seq.push_back(lv);
  endfunction

  task automatic do_record(input bit with_play);
    int t0, lastt, n, iv;
    bit p;
    n = din_seq.size();
    record = 1'b1;
    if (with_play) play = 1'b1;
    t0 = cyc + 1;
    if (m_dout) push(t0, 1'b0, 1'b0);
    m_dout = 1'b0; m_mem.delete(); m_full = 1'b0; p = 1'b0; lastt = t0;
    step();
    chk("rec_entry", int'(recording), 1);
    chk("rec_entry_len", int'(length), 0);
    for (int j = 0; j < n; j++) begin
      din = din_seq[j];
      if (!m_full && din_seq[j] != p) begin
        iv = t0 + j + 1 - lastt;
        m_mem.push_back(iv > CNT_MAX ? CNT_MAX : iv);
        lastt = t0 + j + 1;
        p = din_seq[j];
        if (m_mem.size() == DEPTH) m_full = 1'b1;
      end
      step();
      chk("recording", int'(recording), int'(!m_full));
      chk("length", int'(length), m_mem.size());
      chk("full", int'(full), int'(m_full));
      if (with_play) chk("playing_in_rec", int'(playing), 0);
    end
    record = 1'b0;
    step();
    chk("rec_exit", int'(recording), 0);
    chk("rec_exit_len", int'(length), m_mem.size());
    if (with_play) begin
      chk("no_play_after_rec", int'(playing), 0);
      play = 1'b0;
    end
    step();
  endtask

  task automatic do_play(input int passes, input int abort_off, input bit by_reset);
    int p0, t, L, ab_edge, end_edge;
    int endc[$];
    bit d, aborted;
    L = m_mem.size();
    loop_en = (passes > 1);
    play = 1'b1;
    p0 = cyc + 1;
    if (L == 0) begin
      step(); chk("play_empty", int'(playing), 0);
      step(); chk("play_empty2", int'(playing), 0);
      play = 1'b0; loop_en = 1'b0;
      step();
      return;
    end
    ab_edge = (abort_off > 0) ? p0 + abort_off : 0;
    aborted = 1'b0;
    if (m_dout) push(p0, 1'b0, 1'b0);
    d = 1'b0; t = p0;
    for (int ps = 0; ps < passes && !aborted; ps++)
      for (int i = 0; i < L && !aborted; i++) begin
        t += m_mem[i];
        if (ab_edge != 0 && t >= ab_edge) aborted = 1'b1;
        else if (i < L - 1) begin
          d = !d; push(t, d, 1'b0);
        end else begin
          endc.push_back(t);
          if (ps < passes - 1) begin d = 1'b0; push(t, 1'b0, 1'b1); end
          else begin d = !d; push(t, d, 1'b1); end
        end
      end
    if (aborted) begin
      if (d) push(ab_edge, 1'b0, 1'b0);
      d = 1'b0;
      end_edge = ab_edge;
    end else end_edge = t;
    m_dout = d;
    step();
    chk("play_entry", int'(playing), 1);
    while (cyc < end_edge) begin
      if (passes > 1 && endc.size() >= passes - 1 && cyc == endc[passes-2]) loop_en = 1'b0;
      if (aborted && cyc == end_edge - 1) begin
        if (by_reset) reset = 1'b1; else play = 1'b0;
      end
      step();
    end
    chk("play_exit", int'(playing), 0);
    chk("play_exit_dout", int'(dout), int'(m_dout));
    if (aborted && by_reset) begin
      m_mem.delete(); m_full = 1'b0;
      chk("rst_len", int'(length), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rec", int'(recording), 0);
      reset = 1'b0;
      step(); step();
      chk("play_no_retrigger", int'(playing), 0);
    end
    play = 1'b0; loop_en = 1'b0;
    step(); step();
  endtask

  task automatic rec_reset();
    record = 1'b1;
    if (m_dout) push(cyc + 1, 1'b0, 1'b0);
    m_dout = 1'b0;
    step();
    din = ~din; step();
    din = ~din; step();
    din = ~din; step();
    reset = 1'b1; step();
    chk("rrst_rec", int'(recording), 0);
    chk("rrst_len", int'(length), 0);
    chk("rrst_full", int'(full), 0);
    chk("rrst_dout", int'(dout), 0);
    chk("rrst_play", int'(playing), 0);
    reset = 1'b0; step(); step();
    chk("rec_no_retrigger", int'(recording), 0);
    record = 1'b0; step();
    m_mem.delete(); m_full = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, passes, ab;
    reset = 1'b1; record = 1'b0; play = 1'b0; loop_en = 1'b0; din = 1'b0;
    repeat (3) step();
    chk("reset_dout", int'(dout), 0);
    chk("reset_rec", int'(recording), 0);
    chk("reset_play", int'(playing), 0);
    chk("reset_full", int'(full), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_len", int'(length), 0);
    last_dout = 1'b0; mon_on = 1'b1;
    reset = 1'b0;
    step();

    // 3,5,2 sequence played once
    iv_q = '{3, 5, 2}; build_seq(0);
    do_record(1'b0); do_play(1, 0, 1'b0);
    // loop 2,3 for three passes
    iv_q = '{2, 3}; build_seq(2);
    do_record(1'b0); do_play(3, 0, 1'b0);
    // interval saturation
    iv_q = '{21}; build_seq(1);
    do_record(1'b0); do_play(1, 0, 1'b0);
    // full after DEPTH writes, single-cycle intervals on playback
    iv_q = '{1, 1, 1, 1, 1, 1}; build_seq(3);
    do_record(1'b0); do_play(2, 0, 1'b0);
    // abort mid-pass
    iv_q = '{4, 6, 3}; build_seq(0);
    do_record(1'b0); do_play(1, 7, 1'b0);
    // simultaneous record/play edges
    iv_q = '{2}; build_seq(1);
    do_record(1'b1); do_play(1, 0, 1'b0);
    // reset during record, then play with nothing stored
    rec_reset();
    do_play(1, 0, 1'b0);
    // reset during play
    iv_q = '{3, 4, 5}; build_seq(0);
    do_record(1'b0); do_play(2, 9, 1'b1);

    for (int it = 0; it < 25; it++) begin
      iv_q.delete();
      k = $urandom_range(1, 6);
      repeat (k) iv_q.push_back($urandom_range(1, 20));
      build_seq($urandom_range(0, 3));
      do_record($urandom_range(0, 3) == 0);
      passes = $urandom_range(1, 3);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
      do_play(passes, ab, 1'($urandom_range(0, 1)));
    end

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
